register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_if.sv | 34 +++
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports plus one write port.
// The master drives addresses and write data; the slave returns read data.
interface register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [ADDR_W-1:0] DstReg;
  logic              WriteReg;
  logic [DATA_W-1:0] DstData;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;

  modport master (
    output SrcReg1,
    output SrcReg2,
    output DstReg,
    output WriteReg,
    output DstData,
    input  SrcData1,
    input  SrcData2
  );

  modport slave (
    input  SrcReg1,
    input  SrcReg2,
    input  DstReg,
    input  WriteReg,
    input  DstData,
    output SrcData1,
    output SrcData2
  );
endinterface

// File: rtl/register_file.sv
// 2R1W register file with hardwired-zero R0 and same-cycle write bypass.
// Reset clears storage asynchronously and forces both read ports to zero.
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  register_file_if.slave rf
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;
  logic              zero1, zero2;
  logic              byp1, byp2;
  logic [DATA_W-1:0] src1, src2;

  assign wr_en = rst_n && rf.WriteReg
              && (rf.DstReg != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rf.DstReg] = rf.DstData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // R0 and reset take precedence, so bypass never targets them
  assign zero1 = !rst_n || (rf.SrcReg1 == '0);
  assign zero2 = !rst_n || (rf.SrcReg2 == '0);
  assign byp1  = !zero1 && wr_en
              && (rf.SrcReg1 == rf.DstReg);
  assign byp2  = !zero2 && wr_en
              && (rf.SrcReg2 == rf.DstReg);

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      zero1:   src1 = '0;
      byp1:    src1 = rf.DstData;
      default: src1 = regs_q[rf.SrcReg1];
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      zero2:   src2 = '0;
      byp2:    src2 = rf.DstData;
      default: src2 = regs_q[rf.SrcReg2];
    endcase
  end

  assign rf.SrcData1 = src1;
  assign rf.SrcData2 = src2;
endmodule

// File: tb/tb_register_file.sv
// Randomized bench for register_file against an array model.
// Directed literal checks pin the model on key scenarios.
module tb_register_file;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf ();

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf   (rf)
  );

  int pass_n  = 0;
  int total_n = 0;
  logic [DW-1:0] mem [NR];

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  function automatic logic [DW-1:0]
    expect_rd(input logic [AW-1:0] a);
    if (!rst_n || a == 0) return '0;
    if (rf.WriteReg && rf.DstReg == a)
      return rf.DstData;
    return mem[a];
  endfunction

  task automatic drive(input logic we,
                       input logic [AW-1:0] d,
                       input logic [DW-1:0] dd,
                       input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2);
    rf.WriteReg = we;
    rf.DstReg   = d;
    rf.DstData  = dd;
    rf.SrcReg1  = a1;
    rf.SrcReg2  = a2;
  endtask

  // one cycle: drive, compare at negedge, commit model at posedge
  task automatic tick(input logic we,
                      input logic [AW-1:0] d,
                      input logic [DW-1:0] dd,
                      input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2,
                      input string pnm = "",
                      input logic [DW-1:0] e1 = '0,
                      input logic [DW-1:0] e2 = '0);
    drive(we, d, dd, a1, a2);
    @(negedge clk);
    chk("model_rd1", rf.SrcData1, expect_rd(a1));
    chk("model_rd2", rf.SrcData2, expect_rd(a2));
    if (pnm != "") begin
      chk({pnm, "_rd1"}, rf.SrcData1, e1);
      chk({pnm, "_rd2"}, rf.SrcData2, e2);
    end
    @(posedge clk);
    if (rst_n && we && d != 0) mem[d] = dd;
    #1;
  endtask

  // reset pulse placed between edges; outputs must drop with no clock
  task automatic pulse_reset(input string nm);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) mem[i] = '0;
    chk({nm, "_rd1"}, rf.SrcData1, '0);
    chk({nm, "_rd2"}, rf.SrcData2, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [DW-1:0] shv;
  logic [AW-1:0] rd, ra1, ra2;

  initial begin
    drive(1'b0, '0, '0, 4'd5, 4'd15);
    pulse_reset("reset_hold");
    tick(1'b0, '0, '0, 4'd5, 4'd15,
         "reset_read", 16'h0000, 16'h0000);

    tick(1'b1, 4'd3, 16'hA5A5, 4'd3, 4'd4,
         "wr3_bypass", 16'hA5A5, 16'h0000);
    tick(1'b0, 4'd3, 16'h0000, 4'd3, 4'd4,
         "wr3_read", 16'hA5A5, 16'h0000);

    tick(1'b1, 4'd7, 16'h1111, 4'd0, 4'd0);
    tick(1'b0, '0, '0, 4'd7, 4'd7,
         "r7_init", 16'h1111, 16'h1111);
    tick(1'b1, 4'd7, 16'hBEEF, 4'd7, 4'd7,
         "bypass_both", 16'hBEEF, 16'hBEEF);
    tick(1'b0, '0, '0, 4'd7, 4'd3,
         "r7_after", 16'hBEEF, 16'hA5A5);

    tick(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0,
         "r0_wr", 16'h0000, 16'h0000);
    tick(1'b0, '0, '0, 4'd0, 4'd7,
         "r0_after", 16'h0000, 16'hBEEF);

    tick(1'b1, 4'd6, 16'h0001, 4'd1, 4'd1);
    tick(1'b1, 4'd6, 16'h0002, 4'd6, 4'd1,
         "b2b_byp", 16'h0002, 16'h0000);
    tick(1'b0, '0, '0, 4'd6, 4'd6,
         "b2b_last", 16'h0002, 16'h0002);

    tick(1'b1, 4'd9, 16'h8001, 4'd1, 4'd1);
    tick(1'b0, '0, '0, 4'd9, 4'd9,
         "r9_stored", 16'h8001, 16'h8001);
    drive(1'b1, 4'd9, 16'h1234, 4'd9, 4'd9);
    pulse_reset("async_rst");
    tick(1'b0, '0, '0, 4'd9, 4'd7,
         "rst_discard", 16'h0000, 16'h0000);

    tick(1'b1, 4'd5, 16'h5A5A, 4'd1, 4'd1);
    tick(1'b0, '0, '0, 4'd5, 4'd9,
         "first_wr", 16'h5A5A, 16'h0000);

    tick(1'b1, 4'd2, 16'h8000, 4'd1, 4'd1);
    tick(1'b0, '0, '0, 4'd2, 4'd2,
         "shift_src", 16'h8000, 16'h8000);
    shv = DW'($signed(rf.SrcData1) >>> 4);
    chk("shift_asr4", shv, 16'hF800);

    for (int n = 0; n < 800; n++) begin
      rd  = AW'($urandom_range(0, NR - 1));
      ra1 = ($urandom_range(0, 2) == 0) ? rd
            : AW'($urandom_range(0, NR - 1));
      ra2 = ($urandom_range(0, 2) == 0) ? rd
            : AW'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 99) == 0) begin
        drive(1'b1, rd, DW'($urandom), ra1, ra2);
        pulse_reset("rand_rst");
      end else begin
        tick(($urandom_range(0, 2) != 0), rd,
             DW'($urandom), ra1, ra2);
      end
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
